// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, line geometry and address field extraction.
package icache_pkg;

    typedef enum logic {IDLE, FILL} state_t;

    localparam int LINE_WORDS = 8;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 5;

    function automatic logic [2:0] get_offset(logic [31:0] a);
        return a[OFFSET_LSB +: 3];
    endfunction

    function automatic logic [7:0] get_index(logic [31:0] a, int idx_w);
        return 8'((a >> INDEX_LSB) & ((32'd1 << idx_w) - 32'd1));
    endfunction

    function automatic logic [31:0] get_tag(logic [31:0] a, int idx_w);
        return a >> (INDEX_LSB + idx_w);
    endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and block-read-side signals of the instruction cache.
interface icache_if;

    logic [31:0]  Address_IN;
    logic         Flush_IN;
    logic [31:0]  Instruction_OUT;
    logic         Stall_OUT;
    logic [31:0]  BlockAddress_OUT;
    logic         BlockRead_OUT;
    logic [255:0] Block_IN;

    modport slave (
        input  Address_IN, Flush_IN, Block_IN,
        output Instruction_OUT, Stall_OUT, BlockAddress_OUT, BlockRead_OUT
    );

    modport master (
        output Address_IN, Flush_IN, Block_IN,
        input  Instruction_OUT, Stall_OUT, BlockAddress_OUT, BlockRead_OUT
    );

endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage with combinational read and single-edge line write.
module icache_array #(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [255:0]     rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [255:0]     wr_data
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [255:0]         data [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    always_ff @(posedge clk) begin
        if (rst || flush)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    // tag/data carry no reset: valid alone decides whether a line is usable
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, zero-latency hits and whole-line refill on miss.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES    = 16,
    parameter int MISS_LATENCY = 4
) (
    input logic     CLOCK,
    input logic     RESET,
    icache_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - INDEX_LSB - IDX_W;
    localparam int CNT_W = $clog2(MISS_LATENCY + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [26:0]      line_addr;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [255:0]     rd_data;
    logic [IDX_W-1:0] idx;
    logic [2:0]       off;
    logic             hit, last, wr_en;

    assign idx   = IDX_W'(get_index(bus.Address_IN, IDX_W));
    assign off   = get_offset(bus.Address_IN);
    assign hit   = state == IDLE && rd_valid && rd_tag == TAG_W'(get_tag(bus.Address_IN, IDX_W));
    assign last  = state == FILL && cnt == CNT_W'(MISS_LATENCY - 1);
    // a flush on the final fill edge must leave the line invalid
    assign wr_en = last && !bus.Flush_IN && !RESET;

    icache_array #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .clk     (CLOCK),
        .rst     (RESET),
        .flush   (bus.Flush_IN),
        .rd_idx  (idx),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (IDX_W'(get_index({line_addr, 5'b0}, IDX_W))),
        .wr_tag  (TAG_W'(get_tag({line_addr, 5'b0}, IDX_W))),
        .wr_data (bus.Block_IN)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= state == IDLE ? '0 : cnt + 1'b1;
            if (state == IDLE && !hit)
                line_addr <= bus.Address_IN[31:5];
        end
    end

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (hit ? IDLE : FILL) : (bus.Flush_IN || last ? IDLE : FILL);
    end

    assign bus.Stall_OUT        = !RESET && !hit;
    assign bus.Instruction_OUT  = !RESET && hit ? rd_data[{off, 5'b0} +: 32] : '0;
    assign bus.BlockRead_OUT    = !RESET && state == FILL;
    assign bus.BlockAddress_OUT = bus.BlockRead_OUT ? {line_addr, 5'b0} : '0;

endmodule

// File: tb/tb_icache.sv
// tb_icache: vector table, directed corner sequences and random traffic against a line-level cache model.
module tb_icache;

    localparam int NL = 16;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_if bus();

    icache #(.NUM_LINES(NL), .MISS_LATENCY(ML)) dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // model: which line base address each slot holds, and refill cycles still owed
    bit          m_valid [NL];
    logic [31:0] m_line  [NL];
    int          m_left = 0;
    logic [31:0] m_fill = '0;

    typedef struct {
        logic [31:0] a;
        logic        f;
        logic        r;
        logic        stall;
        logic        br;
        logic [31:0] ba;
        logic [31:0] instr;
    } vec_t;
    vec_t tv[$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a & ~32'h3) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    function automatic logic [255:0] mem_line(logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[32*i +: 32] = mem_word(base + 32'(4 * i));
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    task automatic clear_model();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    // one clock cycle: drive, predict, compare, then advance the model across the edge
    task automatic cycle(logic [31:0] a, logic f, logic r);
        logic [31:0] line_a;
        int          idx;
        bit          hit;
        @(negedge clk);
        bus.Address_IN = a;
        bus.Flush_IN   = f;
        rst            = r;
        if (m_left == 1 && !r)
            bus.Block_IN = mem_line(m_fill);
        else
            for (int i = 0; i < 8; i++) bus.Block_IN[32*i +: 32] = $urandom();
        line_a = a & ~32'h1F;
        idx    = int'((a >> 5) % NL);
        hit    = !r && m_left == 0 && m_valid[idx] && m_line[idx] == line_a;
        #1;
        chk1("model stall", bus.Stall_OUT, !r && !hit);
        chk1("model blockread", bus.BlockRead_OUT, !r && m_left > 0);
        chk("model blockaddr", bus.BlockAddress_OUT, (!r && m_left > 0) ? m_fill : 32'h0);
        chk("model instr", bus.Instruction_OUT, hit ? mem_word(a) : 32'h0);
        if (r) begin
            clear_model();
            m_left = 0;
        end else if (m_left > 0) begin
            if (f) begin
                clear_model();
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_valid[int'((m_fill >> 5) % NL)] = 1'b1;
                    m_line[int'((m_fill >> 5) % NL)]  = m_fill;
                end
            end
        end else begin
            if (f) clear_model();
            if (!hit) begin
                m_left = ML;
                m_fill = line_a;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          mode;
        bus.Address_IN = '0;
        bus.Flush_IN   = 1'b0;
        bus.Block_IN   = '0;
        clear_model();

        // reset, cold miss at 0x40, then the rest of the line as hits
        tv.push_back('{32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
        tv.push_back('{32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
        tv.push_back('{32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0});
        for (int i = 0; i < ML; i++)
            tv.push_back('{32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0});
        for (int i = 0; i < 8; i++)
            tv.push_back('{32'(32'h40 + 4 * i), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mem_word(32'(32'h40 + 4 * i))});
        foreach (tv[i]) begin
            cycle(tv[i].a, tv[i].f, tv[i].r);
            chk1("vec stall", bus.Stall_OUT, tv[i].stall);
            chk1("vec blockread", bus.BlockRead_OUT, tv[i].br);
            chk("vec blockaddr", bus.BlockAddress_OUT, tv[i].ba);
            chk("vec instr", bus.Instruction_OUT, tv[i].instr);
        end

        // conflict: 0x240 shares the index of 0x40 and evicts it
        cycle(32'h40, 1'b0, 1'b0);
        chk1("conflict 0x40 hit", bus.Stall_OUT, 1'b0);
        cycle(32'h240, 1'b0, 1'b0);
        chk1("conflict 0x240 miss", bus.Stall_OUT, 1'b1);
        repeat (ML) cycle(32'h240, 1'b0, 1'b0);
        cycle(32'h240, 1'b0, 1'b0);
        chk("conflict 0x240 data", bus.Instruction_OUT, mem_word(32'h240));
        cycle(32'h40, 1'b0, 1'b0);
        chk1("conflict 0x40 evicted", bus.Stall_OUT, 1'b1);
        repeat (ML) cycle(32'h40, 1'b0, 1'b0);
        cycle(32'h40, 1'b0, 1'b0);

        // flush in fill cycle 2 aborts the 0x80 refill
        cycle(32'h80, 1'b0, 1'b0);
        cycle(32'h80, 1'b0, 1'b0);
        cycle(32'h80, 1'b1, 1'b0);
        chk1("flush during fill", bus.BlockRead_OUT, 1'b1);
        cycle(32'h80, 1'b0, 1'b0);
        chk1("flush drops blockread", bus.BlockRead_OUT, 1'b0);
        chk1("flush line not valid", bus.Stall_OUT, 1'b1);
        for (int i = 0; i < ML; i++) begin
            cycle(32'h80, 1'b0, 1'b0);
            chk("refetch blockaddr", bus.BlockAddress_OUT, 32'h80);
        end
        cycle(32'h80, 1'b0, 1'b0);
        chk1("refetch hit", bus.Stall_OUT, 1'b0);

        // reset in the middle of a fill
        cycle(32'h40, 1'b0, 1'b0);
        repeat (ML) cycle(32'h40, 1'b0, 1'b0);
        cycle(32'h40, 1'b0, 1'b0);
        chk1("0x40 cached", bus.Stall_OUT, 1'b0);
        cycle(32'h100, 1'b0, 1'b0);
        cycle(32'h100, 1'b0, 1'b0);
        cycle(32'h100, 1'b0, 1'b0);
        cycle(32'h100, 1'b0, 1'b1);
        chk1("reset stall", bus.Stall_OUT, 1'b0);
        chk1("reset blockread", bus.BlockRead_OUT, 1'b0);
        cycle(32'h40, 1'b0, 1'b0);
        chk1("post reset 0x40 miss", bus.Stall_OUT, 1'b1);
        repeat (ML) cycle(32'h40, 1'b0, 1'b0);
        cycle(32'h40, 1'b0, 1'b0);

        // late redirect from 0x100 to 0x300 during the fill
        cycle(32'h100, 1'b0, 1'b0);
        for (int i = 0; i < ML; i++) begin
            cycle(32'h300, 1'b0, 1'b0);
            chk("redirect keeps 0x100", bus.BlockAddress_OUT, 32'h100);
        end
        cycle(32'h300, 1'b0, 1'b0);
        chk1("redirect 0x300 miss", bus.Stall_OUT, 1'b1);
        cycle(32'h300, 1'b0, 1'b0);
        chk("redirect second refill", bus.BlockAddress_OUT, 32'h300);
        repeat (ML - 1) cycle(32'h300, 1'b0, 1'b0);
        cycle(32'h304, 1'b0, 1'b0);
        chk("redirect 0x304 data", bus.Instruction_OUT, mem_word(32'h304));

        // random traffic: mostly sequential fetches over 64 lines competing for 16 slots
        a = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            mode = int'($urandom_range(0, 99));
            if (mode < 60)
                a = a + 32'h4;
            else if (mode >= 85)
                a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5) |
                    (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            a = a & 32'h7FF;
            cycle(a, $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
